// File: rtl/pipelined_cskip_adder.sv
// Pipelined carry-skip adder/subtractor: each stage resolves one WIDTH/STAGES slice,
// and a valid/ready handshake with backpressure stalls the whole pipe together.
module pipelined_cskip_adder #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int NB = SW / BLOCK;

  if (STAGES < 1 || BLOCK < 1 || (WIDTH % (BLOCK * STAGES)) != 0) begin : g_bad_params
    $error("pipelined_cskip_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  logic             w_advance;
  logic             w_accept;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic             w_cmsb;

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_bx    [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_cout  [STAGES];
  logic             r_ovf;

  // Per-stage inputs: stage 0 sees the live operands, later stages the previous register.
  logic             w_vin   [STAGES];
  logic [WIDTH-1:0] w_ain   [STAGES];
  logic [WIDTH-1:0] w_bin   [STAGES];
  logic [WIDTH-1:0] w_sbase [STAGES];
  logic [WIDTH-1:0] w_snext [STAGES];
  logic [SW-1:0]    w_sa    [STAGES];
  logic [SW-1:0]    w_sb    [STAGES];
  logic [SW-1:0]    w_ssum  [STAGES];
  logic             w_sc    [STAGES];
  logic             w_scout [STAGES];

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_cout[STAGES-1];
  assign ovf       = r_ovf;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_accept  = in_valid && w_advance;
  assign w_bx      = sub ? ~b : b;
  assign w_c0      = sub ? 1'b1 : cin;

  for (genvar gk = 0; gk < STAGES; gk++) begin : g_stage
    if (gk == 0) begin : g_first
      assign w_vin[gk]   = w_accept;
      assign w_ain[gk]   = a;
      assign w_bin[gk]   = w_bx;
      assign w_sbase[gk] = '0;
      assign w_sc[gk]    = w_c0;
    end else begin : g_next
      assign w_vin[gk]   = r_valid[gk-1];
      assign w_ain[gk]   = r_a[gk-1];
      assign w_bin[gk]   = r_bx[gk-1];
      assign w_sbase[gk] = r_sum[gk-1];
      assign w_sc[gk]    = r_cout[gk-1];
    end

    assign w_sa[gk] = w_ain[gk][gk*SW +: SW];
    assign w_sb[gk] = w_bin[gk][gk*SW +: SW];

    logic [NB:0] w_bc;
    assign w_bc[0]     = w_sc[gk];
    assign w_scout[gk] = w_bc[NB];

    for (genvar gj = 0; gj < NB; gj++) begin : g_blk
      logic [BLOCK-1:0] w_ba;
      logic [BLOCK-1:0] w_bb;
      logic [BLOCK-1:0] w_bs;
      logic [BLOCK:0]   w_rc;
      logic             w_p;

      assign w_ba    = w_sa[gk][gj*BLOCK +: BLOCK];
      assign w_bb    = w_sb[gk][gj*BLOCK +: BLOCK];
      assign w_rc[0] = w_bc[gj];

      for (genvar gi = 0; gi < BLOCK; gi++) begin : g_bit
        assign w_bs[gi]   = w_ba[gi] ^ w_bb[gi] ^ w_rc[gi];
        assign w_rc[gi+1] = (w_ba[gi] & w_bb[gi]) | ((w_ba[gi] ^ w_bb[gi]) & w_rc[gi]);
      end

      // Skip path: a fully propagating block passes its carry-in straight through.
      assign w_p                          = &(w_ba ^ w_bb);
      assign w_bc[gj+1]                   = w_p ? w_bc[gj] : w_rc[BLOCK];
      assign w_ssum[gk][gj*BLOCK +: BLOCK] = w_bs;

      if (gk == STAGES-1 && gj == NB-1) begin : g_msb
        assign w_cmsb = w_rc[BLOCK-1];
      end
    end

    for (genvar gs = 0; gs < STAGES; gs++) begin : g_merge
      if (gs == gk) begin : g_new
        assign w_snext[gk][gs*SW +: SW] = w_ssum[gk];
      end else begin : g_keep
        assign w_snext[gk][gs*SW +: SW] = w_sbase[gk][gs*SW +: SW];
      end
    end
  end

  // Data registers only load on a valid slot so bubbles leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_bx[k]    <= '0;
        r_sum[k]   <= '0;
        r_cout[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_vin[k];
        if (w_vin[k]) begin
          r_a[k]    <= w_ain[k];
          r_bx[k]   <= w_bin[k];
          r_sum[k]  <= w_snext[k];
          r_cout[k] <= w_scout[k];
        end
      end
      if (w_vin[STAGES-1]) begin
        r_ovf <= w_cmsb ^ w_scout[STAGES-1];
      end
    end
  end

endmodule

// File: doc/pipelined_cskip_adder.md
Name: pipelined_cskip_adder

Overview:
- Parametrised, pipelined carry-skip adder/subtractor. Generalises the fixed 64-bit, 4-bit-block carry-skip adder to any width, block size and pipeline depth.
- Adds an add/sub mode, a carry-in, a signed-overflow flag, and a valid/ready handshake with backpressure.
- Sits in the datapath wherever wide additions must close timing at full clock rate. Sustains one result per cycle.

Parameters:
- WIDTH, 64, operand and sum width in bits.
- BLOCK, 4, carry-skip block size in bits.
- STAGES, 2, number of pipeline stages. Each stage computes WIDTH/STAGES bits. Legal values require WIDTH % (BLOCK*STAGES) == 0; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept inputs this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used in add mode only
- sub  in  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1 with cin ignored
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out. In sub mode this is the not-borrow: 1 when a >= b unsigned.
- ovf  out  1  signed overflow = (carry into MSB) XOR (carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits are cleared.
  - sum, cout and ovf go to 0; out_valid goes to 0.
  - in_ready goes to 1 in the first cycle after release.
  - Transactions in flight are discarded and never emerge.
- Datapath:
  - bx = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Slice k covers bits [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES] and is split into BLOCK-bit blocks.
- Block carry logic:
  - Inside a block, carries ripple.
  - Block propagate P = AND over the block of (a[i] ^ bx[i]).
  - Block carry-out = P ? block carry-in : ripple carry-out.
  - The result must equal full-width binary addition bit-for-bit for every input.
- Pipeline organisation:
  - Slice 0 is computed from the live inputs in the accept cycle and registered into stage 0.
  - Stage k (k >= 1) computes slice k from the skewed operands it holds plus the registered slice k-1 carry.
  - Upper operand bits, the sub flag and partial sums travel with their transaction.
  - Stage STAGES-1 is the output register.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stall.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - advance = !out_valid || out_ready.
  - in_ready = advance. This is combinational from out_valid/out_ready only; it does not depend on in_valid.
  - When advance is 1, every stage shifts one step. An empty slot is inserted when no input is accepted.
  - When advance is 0, all stages hold. sum, cout, ovf and out_valid stay stable until consumed.
  - Once out_valid is asserted, it never drops without consumption.
- Throughput: one result per cycle while out_ready = 1. Order is strictly preserved.
- Bubbles: with advance = 1, empty stages shift like full ones. out_valid may go low between results; sum keeps its last value.
- Simultaneous consume + accept in the same cycle is legal and loses no data.
- cout and ovf are meaningful only when out_valid = 1.

Test Plan:
- Add, full propagate chain (WIDTH=64, BLOCK=4, STAGES=2): a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0, cout=1, ovf=0, out_valid 2 cycles after accept.
- Subtract: a=0, b=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Then a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Carry-in and mode: a=0x7FFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1. The same operands with sub=1, cin=1 -> sum=0x7FFF_FFFF_FFFF_FFFF (cin ignored), cout=1, ovf=0.
- Streaming and backpressure: 10 back-to-back inputs with out_ready=1 -> 10 results on consecutive cycles, in order. Then hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, outputs frozen, no loss or duplication after release.
- Reset mid-operation: assert rst_n=0 with 2 transactions in flight -> out_valid=0, sum=0 immediately. After release, none of the old results appear; a new a=3, b=4 -> sum=7.
- Random regression: 10k random a/b/cin/sub with random in_valid/out_ready, checked against a behavioural model, for (64,4,2), (32,8,4), (16,4,1) and (128,16,8).
